// File: rtl/ram_mmio_resp_pkg.sv
// rtl/ram_mmio_resp_pkg.sv - address map constants and lane-merge helper for ram_mmio_resp
package ram_mmio_resp_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h1;
  localparam logic [3:0] REGION_MMIO = 4'h2;

  localparam logic [7:0] OFF_LED         = 8'h00;
  localparam logic [7:0] OFF_MTIME_LO    = 8'h04;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h0C;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h10;
  localparam logic [7:0] OFF_TCTRL       = 8'h14;

  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_PEND_BIT = 1;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/resp_mtimer.sv
// rtl/resp_mtimer.sv - prescaled 64-bit mtime/mtimecmp timer with pending flag
module resp_mtimer
  import ram_mmio_resp_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_off,
  input  logic [3:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        en,
  output logic        pend
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          wr_mlo, wr_mhi, wr_clo, wr_chi, wr_tctrl;
  logic          cmp_hit, w1c;

  assign tick     = en && (presc == PW'(TICK_DIV - 1));
  assign wr_mlo   = wr_en && (wr_off == OFF_MTIME_LO);
  assign wr_mhi   = wr_en && (wr_off == OFF_MTIME_HI);
  assign wr_clo   = wr_en && (wr_off == OFF_MTIMECMP_LO);
  assign wr_chi   = wr_en && (wr_off == OFF_MTIMECMP_HI);
  assign wr_tctrl = wr_en && (wr_off == OFF_TCTRL) && wr_sel[0];
  assign cmp_hit  = en && (mtime >= mtimecmp);
  assign w1c      = wr_tctrl && wr_data[TCTRL_PEND_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      en       <= 1'b0;
      pend     <= 1'b0;
    end else begin
      presc <= (!en || tick) ? '0 : presc + 1'b1;
      // Any software write to mtime suppresses that cycle's increment; the other half holds.
      if (wr_mlo || wr_mhi) begin
        if (wr_mlo) mtime[31:0]  <= lane_merge(mtime[31:0], wr_data, wr_sel);
        if (wr_mhi) mtime[63:32] <= lane_merge(mtime[63:32], wr_data, wr_sel);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr_clo) mtimecmp[31:0]  <= lane_merge(mtimecmp[31:0], wr_data, wr_sel);
      if (wr_chi) mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wr_data, wr_sel);
      if (wr_tctrl) en <= wr_data[TCTRL_EN_BIT];
      // Set has priority over clear so a still-true compare keeps the flag up.
      if (cmp_hit)  pend <= 1'b1;
      else if (w1c) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_mmio_resp.sv
// rtl/ram_mmio_resp.sv - data-memory responder: word RAM, LED register and timer MMIO
module ram_mmio_resp
  import ram_mmio_resp_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int TICK_DIV = 1,
  parameter int LED_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic [LED_W-1:0] led_o,
  output logic             timer_irq_o
);

  logic [31:0]       ram [0:(1<<RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        off;
  logic              is_ram, is_mmio, wr, rd;
  logic [63:0]       tm_mtime, tm_mtimecmp;
  logic              tm_en, tm_pend;
  logic              unused_addr;

  assign ram_idx     = addr_i[RAM_AW+1:2];
  assign off         = addr_i[7:0];
  assign is_ram      = (addr_i[31:28] == REGION_RAM);
  assign is_mmio     = (addr_i[31:28] == REGION_MMIO);
  assign wr          = ce_i && we_i;
  assign rd          = ce_i && !we_i;
  assign unused_addr = ^{addr_i[27:RAM_AW+2], addr_i[1:0]};

  // RAM is not reset; a write coinciding with reset is blocked.
  always_ff @(posedge clk) begin
    if (!rst && wr && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) ram[ram_idx][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_o <= '0;
    end else if (wr && is_mmio && (off == OFF_LED)) begin
      for (int b = 0; b < LED_W; b++) begin
        if (sel_i[b/8]) led_o[b] <= data_i[b];
      end
    end
  end

  resp_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr && is_mmio),
    .wr_off   (off),
    .wr_sel   (sel_i),
    .wr_data  (data_i),
    .mtime    (tm_mtime),
    .mtimecmp (tm_mtimecmp),
    .en       (tm_en),
    .pend     (tm_pend)
  );

  assign timer_irq_o = tm_pend;

  always_comb begin
    data_o = '0;
    if (rd && is_ram) begin
      data_o = ram[ram_idx];
    end else if (rd && is_mmio) begin
      case (off)
        OFF_LED:         data_o[LED_W-1:0] = led_o;
        OFF_MTIME_LO:    data_o = tm_mtime[31:0];
        OFF_MTIME_HI:    data_o = tm_mtime[63:32];
        OFF_MTIMECMP_LO: data_o = tm_mtimecmp[31:0];
        OFF_MTIMECMP_HI: data_o = tm_mtimecmp[63:32];
        OFF_TCTRL: begin
          data_o[TCTRL_EN_BIT]   = tm_en;
          data_o[TCTRL_PEND_BIT] = tm_pend;
        end
        default:         data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mmio_resp.sv
// tb/tb_ram_mmio_resp.sv - scoreboard bench for ram_mmio_resp
module tb_ram_mmio_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [5:0]  led_o;
  logic        timer_irq_o;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic obs = 1'b0;

  localparam logic [31:0] MM = 32'h2000_0000;

  ram_mmio_resp #(.RAM_AW(12), .TICK_DIV(1), .LED_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .sel_i       (sel_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .led_o       (led_o),
    .timer_irq_o (timer_irq_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk);
    #1;
    rst = r; ce_i = c; we_i = w; addr_i = a; data_i = d; sel_i = s; obs = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b0, 1'b1, 1'b1, a, d, s);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic c, input logic [31:0] a, input logic [31:0] e, input string n);
    drive(1'b0, c, 1'b0, a, 32'h0, 4'hF);
    sb.push_back('{0, e, n});
    obs = 1'b1;
  endtask

  task automatic chk(input int k, input logic [31:0] e, input string n);
    idle();
    sb.push_back('{k, e, n});
    obs = 1'b1;
  endtask

  always @(negedge clk) begin
    if (obs) begin
      exp_t        e;
      logic [31:0] act;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: observation with no expected entry");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = data_o;
          1:       act = {26'b0, led_o};
          default: act = {31'b0, timer_irq_o};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    // Reset state
    chk(1, 32'h0, "reset_led");
    chk(2, 32'h0, "reset_irq");
    rd(1'b1, MM + 32'h0C, 32'hFFFF_FFFF, "reset_mtimecmp_lo");
    rd(1'b1, MM + 32'h10, 32'hFFFF_FFFF, "reset_mtimecmp_hi");
    rd(1'b1, MM + 32'h14, 32'h0, "reset_tctrl");
    rd(1'b1, MM + 32'h04, 32'h0, "reset_mtime_lo");

    // RAM byte lanes, unmapped accesses, aliasing
    wr(32'h1000_0010, 32'hAABB_CCDD, 4'b1111);
    wr(32'h1000_0010, 32'h1122_3344, 4'b0101);
    rd(1'b1, 32'h1000_0010, 32'hAA22_CC44, "ram_byte_lanes");
    wr(32'h1000_0000, 32'h1234_5678, 4'b1111);
    wr(32'h3000_0000, 32'hDEAD_BEEF, 4'b1111);
    rd(1'b1, 32'h1000_0000, 32'h1234_5678, "unmapped_write_dropped");
    rd(1'b1, 32'h1000_4000, 32'h1234_5678, "ram_alias");
    rd(1'b0, 32'h1000_0000, 32'h0, "read_ce_low");
    rd(1'b1, 32'h3000_0000, 32'h0, "read_unmapped");
    rd(1'b1, MM + 32'h18, 32'h0, "read_undef_offset");

    // LED register and reset
    wr(MM, 32'hFFFF_FFFF, 4'b1111);
    chk(1, 32'h3F, "led_written");
    rd(1'b1, MM, 32'h0000_003F, "led_readback");
    drive(1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h0, 4'b1111);
    chk(1, 32'h0, "led_after_reset");
    rd(1'b1, 32'h1000_0000, 32'h1234_5678, "ram_write_blocked_by_reset");

    // Timer compare and pending
    wr(MM + 32'h0C, 32'h5, 4'b1111);
    wr(MM + 32'h10, 32'h0, 4'b1111);
    wr(MM + 32'h14, 32'h1, 4'b0001);
    repeat (5) idle();
    rd(1'b1, MM + 32'h04, 32'h5, "mtime_after_5_ticks");
    chk(2, 32'h1, "irq_rises");
    rd(1'b1, MM + 32'h14, 32'h3, "tctrl_pend_set");

    // W1C while compare still true, then after compare made false
    wr(MM + 32'h14, 32'h3, 4'b0001);
    chk(2, 32'h1, "w1c_set_wins");
    wr(MM + 32'h10, 32'hFFFF_FFFF, 4'b1111);
    wr(MM + 32'h14, 32'h3, 4'b0001);
    chk(2, 32'h0, "w1c_clears");
    rd(1'b1, MM + 32'h14, 32'h1, "tctrl_after_clear");

    // Carry into upper word, then write/tick collision
    wr(MM + 32'h08, 32'h0, 4'b1111);
    wr(MM + 32'h04, 32'hFFFF_FFFF, 4'b1111);
    idle();
    rd(1'b1, MM + 32'h04, 32'h0, "carry_lo");
    rd(1'b1, MM + 32'h08, 32'h1, "carry_hi");
    wr(MM + 32'h04, 32'h0000_0100, 4'b1111);
    rd(1'b1, MM + 32'h04, 32'h0000_0100, "write_beats_tick");
    rd(1'b1, MM + 32'h08, 32'h1, "hi_undisturbed");

    // 64-bit wrap
    wr(MM + 32'h08, 32'hFFFF_FFFF, 4'b1111);
    wr(MM + 32'h04, 32'hFFFF_FFFF, 4'b1111);
    rd(1'b1, MM + 32'h08, 32'hFFFF_FFFF, "all_ones_hi");
    rd(1'b1, MM + 32'h08, 32'h0, "wrap_hi");

    idle();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
